// File: rtl/matrix_pkg.sv
// matrix_pkg
// Constants and types shared by the matrix text parser and the matrix displayer.
// Contents:
//   ASCII constants ASC_0, ASC_9, ASC_SP, ASC_CR, ASC_LF
//   MAX_DIM / MAX_ELEMS   storage geometry (5x5 = 25 elements)
//   err_code_e            error reasons reported on err_code
//   parse_state_e         parser state encoding
//   dims_ok()             legality test for requested dimensions
package matrix_pkg;

  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  localparam int MAX_DIM   = 5;
  localparam int MAX_ELEMS = 25;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_DIM  = 2'd1,
    ERR_CHAR = 2'd2,
    ERR_OVF  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEP,
    S_NUM,
    S_FILL,
    S_DONE
  } parse_state_e;

  // Both dimensions must lie in 1..MAX_DIM.
  function automatic logic dims_ok(input logic [2:0] rows, input logic [2:0] cols);
    return (rows != 3'd0) && (cols != 3'd0) &&
           (rows <= 3'(MAX_DIM)) && (cols <= 3'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matrix_input_parser_if.sv
// matrix_input_parser_if
// Bundles the parser's control, UART byte input and storage write port.
//   start/abort/matrix_row/matrix_col : arm and cancel from the control FSM
//   rx_data/rx_valid                  : byte stream from the UART receiver
//   busy/done/err/err_code            : status back to the control FSM
//   wr_en/wr_addr/wr_data             : storage write port
// Modports: master = controller/driver side, slave = the parser.
interface matrix_input_parser_if;

  logic       start;
  logic       abort;
  logic [2:0] matrix_row;
  logic [2:0] matrix_col;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output start, abort, matrix_row, matrix_col, rx_data, rx_valid,
    input  busy, done, err, err_code, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, abort, matrix_row, matrix_col, rx_data, rx_valid,
    output busy, done, err, err_code, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/ascii_classify.sv
// ascii_classify
// Combinational classification of one received byte.
//   rx_data   in  8 : received byte
//   is_digit  out 1 : byte is '0'..'9'
//   is_sep    out 1 : byte is space, CR or LF
//   digit_val out 4 : numeric value of the digit (0 when not a digit)
module ascii_classify
  import matrix_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       is_digit,
  output logic       is_sep,
  output logic [3:0] digit_val
);

  always_comb begin
    is_digit  = (rx_data >= ASC_0) && (rx_data <= ASC_9);
    is_sep    = (rx_data == ASC_SP) || (rx_data == ASC_CR) || (rx_data == ASC_LF);
    digit_val = is_digit ? 4'(rx_data - ASC_0) : 4'd0;
  end

endmodule

// File: rtl/matrix_input_parser.sv
// matrix_input_parser
// Parses a whitespace-separated decimal matrix from the UART byte stream and
// writes the elements row-major into matrix storage, optionally zero-filling
// the remaining addresses up to 24.
//   clk    in : clock
//   rst_n  in : asynchronous active-low reset
//   bus       : matrix_input_parser_if.slave (control, rx bytes, status, write port)
// Parameter FILL_ZERO: 1 = zero the unused tail of storage before done.
module matrix_input_parser
  import matrix_pkg::*;
#(
  parameter bit FILL_ZERO = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  matrix_input_parser_if.slave bus
);

  parse_state_e state_q, state_d;
  logic [4:0]   count_q, count_d;
  logic [4:0]   n_q, n_d;
  logic [7:0]   acc_q, acc_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  err_code_e    err_code_q, err_code_d;
  logic         wr_en_q, wr_en_d;
  logic [4:0]   wr_addr_q, wr_addr_d;
  logic [7:0]   wr_data_q, wr_data_d;

  logic         is_digit;
  logic         is_sep;
  logic [3:0]   digit_val;
  logic [11:0]  acc_next;
  logic         overflow;
  logic [4:0]   count_inc;
  logic [4:0]   elem_total;
  logic         dims_good;
  logic         abort_hit;
  logic         last_elem;
  logic         skip_fill;

  ascii_classify u_classify (
    .rx_data   (bus.rx_data),
    .is_digit  (is_digit),
    .is_sep    (is_sep),
    .digit_val (digit_val)
  );

  // The accumulator never exceeds 255, so 12 bits hold acc*10+digit exactly
  // and the overflow compare cannot be fooled by wraparound.
  assign acc_next   = (12'(acc_q) * 12'd10) + 12'(digit_val);
  assign overflow   = acc_next > 12'd255;
  assign count_inc  = count_q + 5'd1;
  assign elem_total = 5'(bus.matrix_row) * 5'(bus.matrix_col);
  assign dims_good  = dims_ok(bus.matrix_row, bus.matrix_col);
  assign abort_hit  = bus.abort && (state_q != S_IDLE);
  assign last_elem  = (count_inc == n_q);
  assign skip_fill  = !FILL_ZERO || (n_q == 5'(MAX_ELEMS));

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state logic; abort overrides everything once a parse is running.
  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start && dims_good) state_d = S_SEP;
        S_SEP: begin
          if (bus.rx_valid) begin
            if (is_digit)     state_d = S_NUM;
            else if (!is_sep) state_d = S_IDLE;
          end
        end
        S_NUM: begin
          if (bus.rx_valid) begin
            if (is_digit) begin
              if (overflow) state_d = S_IDLE;
            end else if (is_sep) begin
              if (last_elem) state_d = skip_fill ? S_DONE : S_FILL;
              else           state_d = S_SEP;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_FILL: if (count_q == 5'(MAX_ELEMS - 1)) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs. Strobes default low; write address and
  // data hold their last value between writes.
  always_comb begin
    count_d    = count_q;
    n_d        = n_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (!abort_hit) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (dims_good) begin
              n_d     = elem_total;
              count_d = '0;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_DIM;
            end
          end
        end
        S_SEP: begin
          if (bus.rx_valid) begin
            if (is_digit) begin
              acc_d = {4'd0, digit_val};
            end else if (!is_sep) begin
              err_d      = 1'b1;
              err_code_d = ERR_CHAR;
            end
          end
        end
        S_NUM: begin
          if (bus.rx_valid) begin
            if (is_digit) begin
              if (overflow) begin
                err_d      = 1'b1;
                err_code_d = ERR_OVF;
              end else begin
                acc_d = acc_next[7:0];
              end
            end else if (is_sep) begin
              wr_en_d   = 1'b1;
              wr_addr_d = count_q;
              wr_data_d = acc_q;
              count_d   = count_inc;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_CHAR;
            end
          end
        end
        S_FILL: begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = '0;
          count_d   = count_inc;
        end
        S_DONE: done_d = 1'b1;
        default: ;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

endmodule
